// File: rtl/iq_if.sv
// iq_if: rename/writeback/issue bundle between the issue queue and its neighbours.
interface iq_if #(parameter int DEPTH = 8, parameter int TAG_W = 6, parameter int PAYLOAD_W = 96);
  logic                   flush;
  logic                   enq_valid;
  logic                   enq_ready;
  logic [TAG_W-1:0]       enq_rs_tag;
  logic [TAG_W-1:0]       enq_rt_tag;
  logic                   enq_rs_rdy;
  logic                   enq_rt_rdy;
  logic [PAYLOAD_W-1:0]   enq_payload;
  logic                   wb_valid;
  logic [TAG_W-1:0]       wb_tag;
  logic                   iss_valid;
  logic                   iss_ready;
  logic [PAYLOAD_W-1:0]   iss_payload;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output flush, enq_valid, enq_rs_tag, enq_rt_tag, enq_rs_rdy, enq_rt_rdy, enq_payload,
    output wb_valid, wb_tag, iss_ready,
    input  enq_ready, iss_valid, iss_payload, count
  );
  modport slave (
    input  flush, enq_valid, enq_rs_tag, enq_rt_tag, enq_rs_rdy, enq_rt_rdy, enq_payload,
    input  wb_valid, wb_tag, iss_ready,
    output enq_ready, iss_valid, iss_payload, count
  );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: collapsing issue queue; oldest-ready-first selection with tag wakeup.
module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 96
) (
  input logic clk,
  input logic rst,
  iq_if.slave q
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [DEPTH-1:0]     v_q, rs_rdy_q, rt_rdy_q, v_d, rs_rdy_d, rt_rdy_d;
  logic [TAG_W-1:0]     rs_tag_q [DEPTH];
  logic [TAG_W-1:0]     rt_tag_q [DEPTH];
  logic [TAG_W-1:0]     rs_tag_d [DEPTH];
  logic [TAG_W-1:0]     rt_tag_d [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q [DEPTH];
  logic [PAYLOAD_W-1:0] pl_d [DEPTH];
  logic [CW-1:0]        count_q, count_d, enq_at;
  logic [DEPTH:0]       v_x, rs_x, rt_x;
  logic [TAG_W-1:0]     rs_tag_x [DEPTH+1];
  logic [TAG_W-1:0]     rt_tag_x [DEPTH+1];
  logic [PAYLOAD_W-1:0] pl_x [DEPTH+1];
  logic [DEPTH-1:0]     rdy_vec, first;
  logic [PAYLOAD_W-1:0] sel_pl;
  logic                 enq_fire, iss_fire, enq_rs_w, enq_rt_w, pre;
  always_comb begin
    rdy_vec = v_q & rs_rdy_q & rt_rdy_q;
    first = rdy_vec & (~rdy_vec + 1'b1);
    sel_pl = '0;
    for (int i = 0; i < DEPTH; i++) sel_pl = sel_pl | ({PAYLOAD_W{first[i]}} & pl_q[i]);
  end
  assign q.iss_valid   = |rdy_vec && !q.flush;
  assign q.iss_payload = sel_pl;
  assign q.enq_ready   = !rst && !q.flush && count_q < CW'(DEPTH);
  assign q.count       = count_q;
  assign iss_fire      = q.iss_valid && q.iss_ready;
  assign enq_fire      = q.enq_valid && q.enq_ready;
  assign enq_at        = count_q - CW'(iss_fire);
  assign enq_rs_w      = q.enq_rs_rdy || (q.wb_valid && q.wb_tag == q.enq_rs_tag);
  assign enq_rt_w      = q.enq_rt_rdy || (q.wb_valid && q.wb_tag == q.enq_rt_tag);
  // Wakeup-applied view of every slot, padded with an empty slot so the top entry can shift in nothing.
  always_comb begin
    v_x = {1'b0, v_q};
    rs_x = {1'b0, rs_rdy_q};
    rt_x = {1'b0, rt_rdy_q};
    rs_tag_x[DEPTH] = '0;
    rt_tag_x[DEPTH] = '0;
    pl_x[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_x[i] = rs_rdy_q[i] | (q.wb_valid && q.wb_tag == rs_tag_q[i]);
      rt_x[i] = rt_rdy_q[i] | (q.wb_valid && q.wb_tag == rt_tag_q[i]);
      rs_tag_x[i] = rs_tag_q[i];
      rt_tag_x[i] = rt_tag_q[i];
      pl_x[i] = pl_q[i];
    end
  end
  // Slots at or above the issued one take their upper neighbour.
  always_comb begin
    pre = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pre = pre | first[i];
      v_d[i]      = (iss_fire && pre) ? v_x[i+1] : v_x[i];
      rs_rdy_d[i] = (iss_fire && pre) ? rs_x[i+1] : rs_x[i];
      rt_rdy_d[i] = (iss_fire && pre) ? rt_x[i+1] : rt_x[i];
      rs_tag_d[i] = (iss_fire && pre) ? rs_tag_x[i+1] : rs_tag_x[i];
      rt_tag_d[i] = (iss_fire && pre) ? rt_tag_x[i+1] : rt_tag_x[i];
      pl_d[i]     = (iss_fire && pre) ? pl_x[i+1] : pl_x[i];
      if (enq_fire && enq_at == CW'(i)) begin
        v_d[i]      = 1'b1;
        rs_rdy_d[i] = enq_rs_w;
        rt_rdy_d[i] = enq_rt_w;
        rs_tag_d[i] = q.enq_rs_tag;
        rt_tag_d[i] = q.enq_rt_tag;
        pl_d[i]     = q.enq_payload;
      end
    end
    if (q.flush) v_d = '0;
    count_d = q.flush ? '0 : count_q + CW'(enq_fire) - CW'(iss_fire);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q      <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
      count_q  <= '0;
    end else begin
      v_q      <= v_d;
      rs_rdy_q <= rs_rdy_d;
      rt_rdy_q <= rt_rdy_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    rs_tag_q <= rs_tag_d;
    rt_tag_q <= rt_tag_d;
    pl_q     <= pl_d;
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed scenarios plus random traffic checked against a queue-based model.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int PW    = 96;
  typedef struct {
    logic [TAG_W-1:0] rs_tag;
    logic             rs_rdy;
    logic [TAG_W-1:0] rt_tag;
    logic             rt_rdy;
    logic [PW-1:0]    pl;
  } ent_t;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  ent_t mq[$];
  iq_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) q ();
  issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) dut (.clk(clk), .rst(rst), .q(q));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [PW-1:0] rpl();
    return {$urandom, $urandom, $urandom};
  endfunction
  task automatic idle();
    q.flush = 0; q.enq_valid = 0; q.enq_rs_tag = '0; q.enq_rt_tag = '0;
    q.enq_rs_rdy = 1; q.enq_rt_rdy = 1; q.enq_payload = '0;
    q.wb_valid = 0; q.wb_tag = '0; q.iss_ready = 0;
  endtask
  task automatic enq(logic [PW-1:0] pl, logic [TAG_W-1:0] rst_tag, logic rs_r, logic [TAG_W-1:0] rtt, logic rt_r);
    q.enq_valid = 1; q.enq_payload = pl;
    q.enq_rs_tag = rst_tag; q.enq_rs_rdy = rs_r; q.enq_rt_tag = rtt; q.enq_rt_rdy = rt_r;
  endtask
  // Check outputs against the model, then advance one clock and update the model.
  task automatic tick();
    int   sel;
    logic e_er, e_iv, ef, isf, fl, wbv;
    logic [TAG_W-1:0] wbt;
    ent_t ne;
    #1;
    sel = -1;
    foreach (mq[k]) if (sel < 0 && mq[k].rs_rdy && mq[k].rt_rdy) sel = k;
    fl = q.flush;
    e_er = !fl && mq.size() < DEPTH;
    e_iv = sel >= 0 && !fl;
    chk("count", q.count, mq.size());
    chk("enq_ready", q.enq_ready, e_er);
    chk("iss_valid", q.iss_valid, e_iv);
    if (e_iv) chk("iss_payload", q.iss_payload, mq[sel].pl);
    ef = q.enq_valid && e_er;
    isf = e_iv && q.iss_ready;
    wbv = q.wb_valid; wbt = q.wb_tag;
    ne.rs_tag = q.enq_rs_tag; ne.rt_tag = q.enq_rt_tag; ne.pl = q.enq_payload;
    ne.rs_rdy = q.enq_rs_rdy || (wbv && wbt == q.enq_rs_tag);
    ne.rt_rdy = q.enq_rt_rdy || (wbv && wbt == q.enq_rt_tag);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      foreach (mq[k]) if (wbv) begin
        if (mq[k].rs_tag == wbt) mq[k].rs_rdy = 1;
        if (mq[k].rt_tag == wbt) mq[k].rt_rdy = 1;
      end
      if (isf) mq.delete(sel);
      if (ef) mq.push_back(ne);
    end
    @(negedge clk);
  endtask
  initial begin
    logic [PW-1:0] a_pl;
    idle();
    rst = 1;
    @(negedge clk);
    #1;
    chk("rst_count", q.count, 0);
    chk("rst_iss_valid", q.iss_valid, 0);
    chk("rst_enq_ready", q.enq_ready, 0);
    @(negedge clk);
    rst = 0;
    // In-order fill of 8 ready entries, then drain.
    a_pl = rpl();
    enq(a_pl, 1, 1, 2, 1);
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      enq(rpl(), 1, 1, 2, 1);
      tick();
    end
    enq(rpl(), 1, 1, 2, 1);
    #1;
    chk("full_count", q.count, DEPTH);
    chk("full_enq_ready", q.enq_ready, 0);
    chk("full_head", q.iss_payload, a_pl);
    tick();
    idle();
    q.iss_ready = 1;
    for (int i = 0; i < DEPTH; i++) tick();
    tick();
    // Wakeup: older X waits on tag 12, younger Y issues first.
    enq(rpl(), 12, 0, 0, 1); tick();
    enq(rpl(), 3, 1, 0, 1); tick();
    idle(); q.iss_ready = 1; tick();
    q.wb_valid = 1; q.wb_tag = 12; tick();
    q.wb_valid = 0; tick();
    tick();
    // Bypass: Z enqueued while its rt tag broadcasts.
    idle();
    enq(rpl(), 0, 1, 40, 0); q.wb_valid = 1; q.wb_tag = 40; tick();
    idle();
    #1;
    chk("bypass_iss_valid", q.iss_valid, 1);
    q.iss_ready = 1; tick();
    // Simultaneous issue of slot 1 and enqueue of W.
    idle();
    enq(rpl(), 20, 0, 0, 1); tick();
    enq(rpl(), 5, 1, 0, 1); tick();
    enq(rpl(), 21, 0, 0, 1); tick();
    enq(rpl(), 22, 0, 0, 1); q.iss_ready = 1; tick();
    idle();
    #1;
    chk("simul_count", q.count, 3);
    q.wb_valid = 1; q.wb_tag = 22; tick();
    q.wb_tag = 21; tick();
    q.wb_tag = 20; tick();
    idle(); q.iss_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    // Full then flush with iss_ready high.
    idle();
    for (int i = 0; i < DEPTH; i++) begin enq(rpl(), 1, 1, 1, 1); tick(); end
    enq(rpl(), 1, 1, 1, 1); tick();
    q.flush = 1; q.iss_ready = 1;
    #1;
    chk("flush_iss_valid", q.iss_valid, 0);
    tick();
    idle();
    #1;
    chk("flush_count", q.count, 0);
    // Async reset mid-cycle with five entries queued.
    for (int i = 0; i < 5; i++) begin enq(rpl(), 30, 0, 1, 1); tick(); end
    idle();
    #2;
    rst = 1;
    #1;
    chk("arst_count", q.count, 0);
    chk("arst_iss_valid", q.iss_valid, 0);
    chk("arst_enq_ready", q.enq_ready, 0);
    mq.delete();
    @(negedge clk);
    rst = 0;
    enq(rpl(), 2, 1, 3, 1); tick();
    idle(); q.iss_ready = 1; tick();
    // Random traffic with a small tag space so wakeups and bypasses are frequent.
    for (int c = 0; c < 400; c++) begin
      q.flush = ($urandom_range(0, 39) == 0);
      q.enq_valid = $urandom_range(0, 2) != 0;
      q.enq_rs_tag = TAG_W'($urandom_range(0, 7));
      q.enq_rt_tag = TAG_W'($urandom_range(0, 7));
      q.enq_rs_rdy = $urandom_range(0, 1);
      q.enq_rt_rdy = $urandom_range(0, 1);
      q.enq_payload = rpl();
      q.wb_valid = $urandom_range(0, 2) == 0;
      q.wb_tag = TAG_W'($urandom_range(0, 7));
      q.iss_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
